// File: rtl/encoder_level_pkg.sv
// Shared quadrature encodings, direction codes and the transition decoder
// used by the encoder level block.
package encoder_level_pkg;

    localparam logic [1:0] Q_00 = 2'b00;
    localparam logic [1:0] Q_01 = 2'b01;
    localparam logic [1:0] Q_11 = 2'b11;
    localparam logic [1:0] Q_10 = 2'b10;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        CW      = 2'd1,
        CCW     = 2'd2,
        ILLEGAL = 2'd3
    } dir_t;

    typedef enum logic {
        UNPRIMED = 1'b0,
        TRACK    = 1'b1
    } enc_state_t;

    // Position of a Gray-coded {A,B} pair along the clockwise cycle.
    function automatic logic [1:0] quad_pos(input logic [1:0] ab);
        logic [1:0] pos;
        case (ab)
            Q_00:    pos = 2'd0;
            Q_01:    pos = 2'd1;
            Q_11:    pos = 2'd2;
            default: pos = 2'd3;
        endcase
        return pos;
    endfunction

    function automatic dir_t quad_dir(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] delta;
        dir_t       dir;
        delta = quad_pos(cur) - quad_pos(prev);
        case (delta)
            2'd0:    dir = NONE;
            2'd1:    dir = CW;
            2'd3:    dir = CCW;
            default: dir = ILLEGAL;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/encoder_level_debounce_ch.sv
// One encoder channel: 2-flop synchronizer followed by a strobe-sampled
// history register that accepts a new value only after DEBOUNCE agreeing samples.
module debounce_ch #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    input  logic raw,
    output logic sample,
    output logic agree,
    output logic deb
);

    logic                sync_p0;
    logic                sync_p1;
    logic [DEBOUNCE-1:0] hist;
    logic [DEBOUNCE-1:0] hist_nxt;

    // History as it will look after this strobe, new sample included.
    assign hist_nxt = {hist[DEBOUNCE-2:0], sync_p1};
    assign agree    = (hist_nxt == '0) || (hist_nxt == '1);
    assign sample   = sync_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            hist    <= '0;
            deb     <= 1'b0;
        end else begin
            // stage p0 -> p1: metastability synchronizer
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            if (strobe) begin
                hist <= hist_nxt;
                if (agree && (hist_nxt[0] != deb)) begin
                    deb <= hist_nxt[0];
                end
            end
        end
    end

endmodule

// File: rtl/encoder_level.sv
// Quadrature encoder to level converter: debounced channels feed a transition
// decoder and a saturating or wrapping up/down level register.
module encoder_level
    import encoder_level_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 4,
    parameter int STEP     = 1,
    parameter int WRAP     = 0,
    parameter int INIT     = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             strobe,
    input  logic             enc_a,
    input  logic             enc_b,
    output logic [WIDTH-1:0] level,
    output logic             changed,
    output logic             err
);

    localparam logic [WIDTH-1:0] INIT_X   = WIDTH'(INIT);
    localparam logic [WIDTH:0]   STEP_X   = (WIDTH + 1)'(STEP);
    localparam logic [4:0]       FILL_MAX = 5'(DEBOUNCE - 1);

    logic       deb_a, deb_b;
    logic       agree_a, agree_b;
    logic       sample_a, sample_b;
    logic [1:0] ab_p0;
    logic [1:0] prev_ab_p1;
    logic [4:0] fill_cnt;
    enc_state_t state;
    dir_t       dir;

    function automatic logic [WIDTH-1:0] inc_level(input logic [WIDTH-1:0] cur);
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] res;
        sum = {1'b0, cur} + STEP_X;
        if ((WRAP == 0) && sum[WIDTH]) begin
            res = '1;
        end else begin
            res = sum[WIDTH-1:0];
        end
        return res;
    endfunction

    function automatic logic [WIDTH-1:0] dec_level(input logic [WIDTH-1:0] cur);
        logic [WIDTH:0]   diff;
        logic [WIDTH-1:0] res;
        diff = {1'b0, cur} - STEP_X;
        if ((WRAP == 0) && diff[WIDTH]) begin
            res = '0;
        end else begin
            res = diff[WIDTH-1:0];
        end
        return res;
    endfunction

    debounce_ch #(.DEBOUNCE(DEBOUNCE)) u_ch_a (
        .clk    (clk),
        .reset  (reset),
        .strobe (strobe),
        .raw    (enc_a),
        .sample (sample_a),
        .agree  (agree_a),
        .deb    (deb_a)
    );

    debounce_ch #(.DEBOUNCE(DEBOUNCE)) u_ch_b (
        .clk    (clk),
        .reset  (reset),
        .strobe (strobe),
        .raw    (enc_b),
        .sample (sample_b),
        .agree  (agree_b),
        .deb    (deb_b)
    );

    assign ab_p0 = {deb_a, deb_b};
    assign dir   = quad_dir(prev_ab_p1, ab_p0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= UNPRIMED;
            fill_cnt   <= '0;
            prev_ab_p1 <= Q_00;
            level      <= INIT_X;
            changed    <= 1'b0;
            err        <= 1'b0;
        end else begin
            changed <= 1'b0;
            err     <= 1'b0;
            case (state)
                // Priming waits until both histories hold DEBOUNCE fresh samples,
                // so stale post-reset zeros are never adopted as a position.
                UNPRIMED: begin
                    if (strobe) begin
                        if (fill_cnt != FILL_MAX) begin
                            fill_cnt <= fill_cnt + 5'd1;
                        end
                        if ((fill_cnt == FILL_MAX) && agree_a && agree_b) begin
                            prev_ab_p1 <= {sample_a, sample_b};
                            state      <= TRACK;
                        end
                    end
                end
                // stage p0 -> p1: decode the debounced step, update level
                default: begin
                    prev_ab_p1 <= ab_p0;
                    case (dir)
                        CW: begin
                            level   <= inc_level(level);
                            changed <= (inc_level(level) != level);
                        end
                        CCW: begin
                            level   <= dec_level(level);
                            changed <= (dec_level(level) != level);
                        end
                        ILLEGAL: err <= 1'b1;
                        default: ;
                    endcase
                end
            endcase
        end
    end

endmodule
